// File: rtl/nodf_module_intf.sv
// Passive ap_ctrl_chain handshake tracker: transaction state, count, latency and stall statistics.
// Optional stall counter built only when NODF_STALL_STAT_EN is defined.
module nodf_module_intf #(
    parameter int CNT_W = 32,
    parameter int LAT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_continue,
    input  logic             finish,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] txn_count,
    output logic [LAT_W-1:0] last_latency,
    output logic [LAT_W-1:0] max_latency,
    output logic             lat_valid,
    output logic [LAT_W-1:0] stall_cycles,
    output logic             protocol_err,
    output logic             finished
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_WAIT     = 2'd2,
        ST_FINISHED = 2'd3
    } state_t;

    localparam logic [LAT_W-1:0] LAT_ONE = {{(LAT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LAT_W-1:0] r_lat_cnt;
    logic [LAT_W-1:0] w_lat_nxt;
    logic             w_complete;
    logic             w_err_set;
    logic [CNT_W-1:0] r_txn_count;
    logic [LAT_W-1:0] r_last_latency;
    logic [LAT_W-1:0] r_max_latency;
    logic             r_lat_valid;
    logic             r_protocol_err;
    logic             r_finished;

    // Next-state, latency-counter and event decode
    always_comb begin
        w_state_nxt = r_state;
        w_lat_nxt   = r_lat_cnt;
        w_complete  = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ap_done || ap_ready) begin
                    w_err_set = 1'b1;
                end else begin
                    w_err_set = 1'b0;
                end
                if (ap_start) begin
                    w_state_nxt = ST_RUN;
                    w_lat_nxt   = LAT_ONE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (ap_done) begin
                    if (ap_continue) begin
                        w_complete = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end else begin
                    w_lat_nxt = (&r_lat_cnt) ? r_lat_cnt : r_lat_cnt + LAT_ONE;
                end
            end
            ST_WAIT: begin
                if (ap_continue) begin
                    w_complete = 1'b1;
                end else begin
                    w_complete = 1'b0;
                end
                // ap_done must stay asserted until the downstream acknowledges it
                if (ap_ready || (!ap_done && !ap_continue)) begin
                    w_err_set = 1'b1;
                end else begin
                    w_err_set = 1'b0;
                end
            end
            ST_FINISHED: begin
                w_state_nxt = ST_FINISHED;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (w_complete) begin
            if (ap_start) begin
                w_state_nxt = ST_RUN;
                w_lat_nxt   = LAT_ONE;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end else begin
            w_lat_nxt = w_lat_nxt;
        end
        // End of run overrides everything and freezes the statistics
        if (finish) begin
            w_state_nxt = ST_FINISHED;
            w_lat_nxt   = r_lat_cnt;
            w_complete  = 1'b0;
            w_err_set   = 1'b0;
        end else begin
            w_err_set = w_err_set;
        end
    end

    // State, latency counter and statistics registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_lat_cnt      <= {LAT_W{1'b0}};
            r_txn_count    <= {CNT_W{1'b0}};
            r_last_latency <= {LAT_W{1'b0}};
            r_max_latency  <= {LAT_W{1'b0}};
            r_lat_valid    <= 1'b0;
            r_protocol_err <= 1'b0;
            r_finished     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_lat_cnt   <= w_lat_nxt;
            r_lat_valid <= w_complete;
            if (w_complete) begin
                r_txn_count    <= (&r_txn_count) ? r_txn_count : r_txn_count + CNT_ONE;
                r_last_latency <= r_lat_cnt;
                if (r_lat_cnt > r_max_latency) begin
                    r_max_latency <= r_lat_cnt;
                end
            end
            if (w_err_set) begin
                r_protocol_err <= 1'b1;
            end
            if (finish) begin
                r_finished <= 1'b1;
            end
        end
    end

`ifdef NODF_STALL_STAT_EN
    logic [LAT_W-1:0] r_stall_cycles;

    // Count cycles spent waiting for ap_continue
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= {LAT_W{1'b0}};
        end else if ((r_state == ST_WAIT) && !finish && !(&r_stall_cycles)) begin
            r_stall_cycles <= r_stall_cycles + LAT_ONE;
        end
    end

    assign stall_cycles = r_stall_cycles;
`else
    assign stall_cycles = {LAT_W{1'b0}};
`endif

    assign state        = r_state;
    assign txn_count    = r_txn_count;
    assign last_latency = r_last_latency;
    assign max_latency  = r_max_latency;
    assign lat_valid    = r_lat_valid;
    assign protocol_err = r_protocol_err;
    assign finished     = r_finished;

endmodule

// File: tb/tb_nodf_module_intf.sv
// Directed bench for nodf_module_intf; expectations computed by hand from the edge-by-edge behaviour.
module tb_nodf_module_intf;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ap_start = 1'b0;
    logic        ap_ready = 1'b0;
    logic        ap_done = 1'b0;
    logic        ap_continue = 1'b0;
    logic        finish = 1'b0;
    logic [1:0]  state;
    logic [31:0] txn_count;
    logic [31:0] last_latency;
    logic [31:0] max_latency;
    logic        lat_valid;
    logic [31:0] stall_cycles;
    logic        protocol_err;
    logic        finished;

    int total = 0;
    int bad   = 0;

`ifdef NODF_STALL_STAT_EN
    localparam logic [31:0] STALL_EXP = 32'd4;
`else
    localparam logic [31:0] STALL_EXP = 32'd0;
`endif

    nodf_module_intf #(.CNT_W(32), .LAT_W(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .ap_start     (ap_start),
        .ap_ready     (ap_ready),
        .ap_done      (ap_done),
        .ap_continue  (ap_continue),
        .finish       (finish),
        .state        (state),
        .txn_count    (txn_count),
        .last_latency (last_latency),
        .max_latency  (max_latency),
        .lat_valid    (lat_valid),
        .stall_cycles (stall_cycles),
        .protocol_err (protocol_err),
        .finished     (finished)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drive(input logic s, input logic d, input logic c, input logic f);
        ap_start    = s;
        ap_done     = d;
        ap_continue = c;
        finish      = f;
    endtask

    initial begin
        #12 reset = 1'b0;
        #1;
        chk("rst_state", state, 2'd0);
        chk("rst_txn", txn_count, 32'd0);
        chk("rst_lv", lat_valid, 1'b0);
        chk("rst_err", protocol_err, 1'b0);
        chk("rst_fin", finished, 1'b0);

        // Idle, then finish
        tick(19);
        chk("idle_state", state, 2'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1);
        chk("fin_state", state, 2'd3);
        chk("fin_flag", finished, 1'b1);
        chk("fin_txn", txn_count, 32'd0);
        chk("fin_err", protocol_err, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick(2);
        chk("fin_hold", state, 2'd3);
        #2 reset = 1'b1;
        #1 chk("rst1_state", state, 2'd0);
        chk("rst1_fin", finished, 1'b0);
        #2 reset = 1'b0;

        // Single transaction: start edge, 4 idle edges, done edge -> latency 5
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1);
        chk("t1_run", state, 2'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick(4);
        chk("t1_novalid", lat_valid, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        tick(1);
        chk("t1_state", state, 2'd0);
        chk("t1_lv", lat_valid, 1'b1);
        chk("t1_txn", txn_count, 32'd1);
        chk("t1_last", last_latency, 32'd5);
        chk("t1_max", max_latency, 32'd5);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);
        chk("t1_lv_pulse", lat_valid, 1'b0);

        // Back-to-back: latency 3, then minimum latency 1
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        tick(3);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        tick(1);
        chk("b2b_state", state, 2'd1);
        chk("b2b_txn", txn_count, 32'd2);
        chk("b2b_last", last_latency, 32'd3);
        chk("b2b_max", max_latency, 32'd5);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        tick(1);
        chk("min_state", state, 2'd0);
        chk("min_txn", txn_count, 32'd3);
        chk("min_last", last_latency, 32'd1);
        chk("min_max", max_latency, 32'd5);

        // Stall: done held with continue low for 4 cycles, latency 2
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("st_wait", state, 2'd2);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        tick(1);
        chk("st_state", state, 2'd0);
        chk("st_txn", txn_count, 32'd4);
        chk("st_last", last_latency, 32'd2);
        chk("st_stall", stall_cycles, STALL_EXP);
        chk("st_noerr", protocol_err, 1'b0);

        // ap_done in IDLE is a protocol error, sticky
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1);
        chk("pe_set", protocol_err, 1'b1);
        chk("pe_state", state, 2'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick(2);
        chk("pe_sticky", protocol_err, 1'b1);
        chk("pe_txn", txn_count, 32'd4);

        // finish during RUN, coincident with done+continue: transaction discarded
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        tick(2);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        tick(1);
        chk("fr_state", state, 2'd3);
        chk("fr_txn", txn_count, 32'd4);
        chk("fr_lv", lat_valid, 1'b0);
        chk("fr_fin", finished, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        tick(2);
        chk("fr_hold", state, 2'd3);
        chk("fr_txn_hold", txn_count, 32'd4);
        chk("fr_stall", stall_cycles, STALL_EXP);
        #2 reset = 1'b1;
        #1;
        chk("rst2_state", state, 2'd0);
        chk("rst2_txn", txn_count, 32'd0);
        chk("rst2_last", last_latency, 32'd0);
        chk("rst2_max", max_latency, 32'd0);
        chk("rst2_stall", stall_cycles, 32'd0);
        chk("rst2_err", protocol_err, 1'b0);
        chk("rst2_fin", finished, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
